// File: rtl/w_forward_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : w_forward_demux_if
// Description : Write-beat bundle between the master side and the per-bank
//               W forward paths. The slave modport is the demux view; the
//               master modport is the upstream/downstream driver view.
// Revision    : 1.0 - initial release
// ============================================================================
interface w_forward_demux_if #(
    parameter int DATA_W    = 77,
    parameter int NUM_BANKS = 4
);
    logic [DATA_W-1:0]    DATAi;
    logic                 VALIDi;
    logic                 READYi;
    logic [DATA_W-1:0]    DATAo;
    logic [NUM_BANKS-1:0] VALIDo;
    logic [NUM_BANKS-1:0] READYo;

    modport slave (
        input  DATAi, VALIDi, READYo,
        output READYi, DATAo, VALIDo
    );

    modport master (
        output DATAi, VALIDi, READYo,
        input  READYi, DATAo, VALIDo
    );
endinterface
`default_nettype wire

// File: rtl/w_forward_demux.sv
`default_nettype none
// ============================================================================
// Module      : w_forward_demux
// Description : Write-channel burst router. Decodes the header beat address
//               against NUM_BANKS mask/base pairs, forwards the whole burst to
//               the lowest-index matching bank, or sinks it on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module w_forward_demux #(
    parameter int                          DATA_W     = 77,
    parameter int                          ADDR_LSB   = 33,
    parameter int                          ADDR_W     = 36,
    parameter int                          NUM_BANKS  = 4,
    parameter logic [NUM_BANKS*ADDR_W-1:0] BANK_MASKS = '0,
    parameter logic [NUM_BANKS*ADDR_W-1:0] BANK_BASES = '0,
    parameter int                          MAX_BEATS  = 256,
    localparam int                         SEL_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    w_forward_demux_if.slave      bus,
    output logic                  BUSY,
    output logic [SEL_W-1:0]      SEL,
    output logic                  MISS,
    output logic                  OVERRUN
);

    localparam int              CNT_W    = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                 state, next_state;
    logic [SEL_W-1:0]       sel_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   miss_next;
    logic                   overrun_next;
    logic [ADDR_W-1:0]      addr;
    logic [SEL_W-1:0]       win_idx;
    logic                   hit_any;
    logic                   ready_up;
    logic [NUM_BANKS-1:0]   valid_dn;
    logic                   last_beat;

    assign addr      = bus.DATAi[ADDR_LSB+ADDR_W-1:ADDR_LSB];
    assign last_beat = bus.DATAi[0];

    // Address decode; scanning high to low lets the lowest matching index win
    always_comb begin
        win_idx = '0;
        hit_any = 1'b0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if ((addr & BANK_MASKS[i*ADDR_W +: ADDR_W]) == BANK_BASES[i*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                win_idx = SEL_W'(i);
            end
        end
    end

    // State and bookkeeping registers; reset abandons any partial burst
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            SEL     <= '0;
            cnt     <= '0;
            MISS    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            state   <= next_state;
            SEL     <= sel_next;
            cnt     <= cnt_next;
            MISS    <= miss_next;
            OVERRUN <= overrun_next;
        end
    end

    // Next-state and handshake steering; the header is only consumed after the decode cycle
    always_comb begin
        next_state   = state;
        sel_next     = SEL;
        cnt_next     = cnt;
        miss_next    = 1'b0;
        overrun_next = OVERRUN;
        ready_up     = 1'b0;
        valid_dn     = '0;
        case (state)
            IDLE: begin
                if (bus.VALIDi) begin
                    cnt_next = '0;
                    if (hit_any) begin
                        sel_next   = win_idx;
                        next_state = ROUTE;
                    end else begin
                        miss_next  = 1'b1;
                        next_state = DROP;
                    end
                end
            end
            ROUTE: begin
                valid_dn[SEL] = bus.VALIDi;
                ready_up      = bus.READYo[SEL];
                if (bus.VALIDi && bus.READYo[SEL]) begin
                    cnt_next = cnt + 1'b1;
                    if (last_beat) begin
                        next_state = IDLE;
                    end else if (cnt == LAST_CNT) begin
                        // Burst too long: stop feeding the bank, sink the tail
                        overrun_next = 1'b1;
                        next_state   = DROP;
                    end
                end
            end
            DROP: begin
                ready_up = 1'b1;
                if (bus.VALIDi) begin
                    cnt_next = cnt + 1'b1;
                    if (last_beat) begin
                        next_state = IDLE;
                    end else if (cnt == LAST_CNT) begin
                        overrun_next = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.DATAo  = bus.DATAi;
    assign bus.VALIDo = valid_dn;
    assign bus.READYi = ready_up;
    assign BUSY       = (state != IDLE);

endmodule
`default_nettype wire
